// File: rtl/cnn_pkg.sv
// Shared definitions for the CNN front end (image-load stage and window generator).
package cnn_pkg;

  localparam int DATA_SIZE      = 16;
  localparam int BUF_ADDR_WIDTH = 10;
  localparam int IMG_SIZE_WIDTH = 6;
  localparam int COORD_WIDTH    = 5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FILL,
    ST_PRESENT,
    ST_SHIFT,
    ST_DONE
  } win_state_t;

endpackage

// File: rtl/window_shift_reg.sv
// KxK pixel window register: whole-window column shift-left, or single element write.
module window_shift_reg #(
  parameter int KSIZE     = 5,
  parameter int DATA_SIZE = 16,
  parameter int IDX_W     = 3
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             shift,
  input  logic                             wr_en,
  input  logic [IDX_W-1:0]                 wr_row,
  input  logic [IDX_W-1:0]                 wr_col,
  input  logic [DATA_SIZE-1:0]             wr_data,
  output logic [KSIZE*KSIZE*DATA_SIZE-1:0] win_data
);

  // Shift wins over a write; the controller never asks for both in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      win_data <= '0;
    end else if (shift) begin
      for (int r = 0; r < KSIZE; r++) begin
        for (int c = 0; c < KSIZE - 1; c++) begin
          win_data[(r*KSIZE+c)*DATA_SIZE +: DATA_SIZE] <=
            win_data[(r*KSIZE+c+1)*DATA_SIZE +: DATA_SIZE];
        end
      end
    end else if (wr_en) begin
      win_data[(int'(wr_row)*KSIZE + int'(wr_col))*DATA_SIZE +: DATA_SIZE] <= wr_data;
    end
  end

endmodule

// File: rtl/conv_window_gen.sv
// Streams every KxK stride-1 window of an NxN image held in the image buffer,
// refetching only the new rightmost column when sliding along a row.
module conv_window_gen #(
  parameter int KSIZE          = 5,
  parameter int DATA_SIZE      = cnn_pkg::DATA_SIZE,
  parameter int BUF_ADDR_WIDTH = cnn_pkg::BUF_ADDR_WIDTH,
  parameter int IMG_SIZE_WIDTH = cnn_pkg::IMG_SIZE_WIDTH
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 start,
  input  logic [IMG_SIZE_WIDTH-1:0]            img_size,
  output logic                                 busy,
  output logic                                 done,
  output logic                                 rd_en,
  output logic [BUF_ADDR_WIDTH-1:0]            rd_addr,
  input  logic [DATA_SIZE-1:0]                 rd_data,
  output logic                                 win_valid,
  input  logic                                 win_ready,
  output logic [KSIZE*KSIZE*DATA_SIZE-1:0]     win_data,
  output logic [cnn_pkg::COORD_WIDTH-1:0]      win_row,
  output logic [cnn_pkg::COORD_WIDTH-1:0]      win_col,
  output logic                                 win_last
);

  import cnn_pkg::*;

  localparam int IDX_W = (KSIZE > 1) ? $clog2(KSIZE) : 1;
  localparam int CW    = COORD_WIDTH;

  win_state_t                state;
  logic [IMG_SIZE_WIDTH-1:0] n;
  logic [CW-1:0]             row;
  logic [CW-1:0]             col;
  logic [IDX_W-1:0]          rr;
  logic [IDX_W-1:0]          cc;
  logic                      more;
  logic [IMG_SIZE_WIDTH-1:0] span;
  logic                      at_row_end;
  logic                      at_last;
  logic                      shift;
  logic                      cap_vld_p1;
  logic [IDX_W-1:0]          cap_row_p1;
  logic [IDX_W-1:0]          cap_col_p1;

  function automatic logic [BUF_ADDR_WIDTH-1:0] pix_addr(
    input logic [CW-1:0]             base_r,
    input logic [IDX_W-1:0]          off_r,
    input logic [CW-1:0]             base_c,
    input logic [IDX_W-1:0]          off_c,
    input logic [IMG_SIZE_WIDTH-1:0] width
  );
    logic [BUF_ADDR_WIDTH-1:0] y;
    logic [BUF_ADDR_WIDTH-1:0] x;
    y = BUF_ADDR_WIDTH'(base_r) + BUF_ADDR_WIDTH'(off_r);
    x = BUF_ADDR_WIDTH'(base_c) + BUF_ADDR_WIDTH'(off_c);
    return y * BUF_ADDR_WIDTH'(width) + x;
  endfunction

  // Last legal top-left coordinate is N-K in both directions.
  assign span       = n - IMG_SIZE_WIDTH'(KSIZE);
  assign at_row_end = (IMG_SIZE_WIDTH'(col) == span);
  assign at_last    = at_row_end && (IMG_SIZE_WIDTH'(row) == span);

  // Reads are issued straight from the walk counters so the first one lands the cycle after start.
  assign rd_en   = ((state == ST_FILL) || (state == ST_SHIFT)) && more;
  assign rd_addr = rd_en ? pix_addr(row, rr, col, cc, n) : '0;

  // Slide the window on a handshake that stays on the same row.
  assign shift = (state == ST_PRESENT) && win_ready && !win_last && !at_row_end;

  // Stage p1: read strobe delayed to line up with rd_data; reset drops in-flight reads.
  always_ff @(posedge clk) begin
    if (rst) begin
      cap_vld_p1 <= 1'b0;
    end else begin
      cap_vld_p1 <= rd_en;
    end
  end

  // Stage p1: window position of the read whose data arrives this cycle.
  always_ff @(posedge clk) begin
    cap_row_p1 <= rr;
    cap_col_p1 <= cc;
  end

  // Control FSM: start/size capture, read walk, presentation and handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      n         <= '0;
      row       <= '0;
      col       <= '0;
      rr        <= '0;
      cc        <= '0;
      more      <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      win_valid <= 1'b0;
      win_last  <= 1'b0;
      win_row   <= '0;
      win_col   <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            n    <= img_size;
            done <= 1'b0;
            row  <= '0;
            col  <= '0;
            rr   <= '0;
            cc   <= '0;
            if (img_size < IMG_SIZE_WIDTH'(KSIZE)) begin
              state <= ST_DONE;
              done  <= 1'b1;
            end else begin
              state <= ST_FILL;
              busy  <= 1'b1;
              more  <= 1'b1;
            end
          end
        end
        ST_FILL, ST_SHIFT: begin
          // Column-major walk; SHIFT starts on the last column so it stops after K reads.
          if (more) begin
            if (rr == IDX_W'(KSIZE - 1)) begin
              rr <= '0;
              if (cc == IDX_W'(KSIZE - 1)) more <= 1'b0;
              else cc <= cc + 1'b1;
            end else begin
              rr <= rr + 1'b1;
            end
          end else begin
            state     <= ST_PRESENT;
            win_valid <= 1'b1;
            win_row   <= row;
            win_col   <= col;
            win_last  <= at_last;
          end
        end
        ST_PRESENT: begin
          if (win_ready) begin
            win_valid <= 1'b0;
            win_last  <= 1'b0;
            rr        <= '0;
            if (win_last) begin
              state <= ST_DONE;
              done  <= 1'b1;
              busy  <= 1'b0;
            end else if (at_row_end) begin
              row   <= row + 1'b1;
              col   <= '0;
              cc    <= '0;
              more  <= 1'b1;
              state <= ST_FILL;
            end else begin
              col   <= col + 1'b1;
              cc    <= IDX_W'(KSIZE - 1);
              more  <= 1'b1;
              state <= ST_SHIFT;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  window_shift_reg #(
    .KSIZE     (KSIZE),
    .DATA_SIZE (DATA_SIZE),
    .IDX_W     (IDX_W)
  ) u_window (
    .clk      (clk),
    .rst      (rst),
    .shift    (shift),
    .wr_en    (cap_vld_p1),
    .wr_row   (cap_row_p1),
    .wr_col   (cap_col_p1),
    .wr_data  (rd_data),
    .win_data (win_data)
  );

endmodule

// File: tb/tb_conv_window_gen.sv
// Bench for conv_window_gen: table of image runs plus hand-written corner sequences,
// all compared against a window model built from the image memory.
module tb_conv_window_gen;

  localparam int K  = 5;
  localparam int KK = K * K;
  localparam int DW = 16;
  localparam int WW = K * K * DW;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [5:0]    img_size;
  logic          busy;
  logic          done;
  logic          rd_en;
  logic [9:0]    rd_addr;
  logic [15:0]   rd_data = '0;
  logic          win_valid;
  logic          win_ready;
  logic [WW-1:0] win_data;
  logic [4:0]    win_row;
  logic [4:0]    win_col;
  logic          win_last;

  conv_window_gen #(.KSIZE(K)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .img_size  (img_size),
    .busy      (busy),
    .done      (done),
    .rd_en     (rd_en),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .win_valid (win_valid),
    .win_ready (win_ready),
    .win_data  (win_data),
    .win_row   (win_row),
    .win_col   (win_col),
    .win_last  (win_last)
  );

  always #5 clk = ~clk;

  logic [15:0] mem [1024];

  // Image buffer with a one-cycle read latency.
  always @(posedge clk) if (rd_en === 1'b1) rd_data <= mem[rd_addr];

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  logic [WW-1:0] got_data [$];
  int got_row [$];
  int got_col [$];
  int got_last [$];
  int valid_cyc [$];
  int hs_cyc [$];
  int bursts [$];
  int done_cyc, reads, present_reads, stable_errs, busy_errs, post_errs;

  typedef struct {
    int n;
    bit rnd_ready;
    bit rnd_mem;
    int exp_win;
    int exp_done;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic fill_mem(input bit rnd);
    for (int i = 0; i < 1024; i++) mem[i] = rnd ? 16'($urandom) : 16'(i);
  endtask

  // Start one image and record everything the DUT does until done.
  task automatic run_image(input int n, input bit rnd, input int dup_at);
    int rd_since;
    bit prev_stall, prev_valid, pl;
    logic [WW-1:0] pd;
    logic [4:0] pr, pc;
    got_data.delete(); got_row.delete(); got_col.delete(); got_last.delete();
    valid_cyc.delete(); hs_cyc.delete(); bursts.delete();
    done_cyc = -1; reads = 0; present_reads = 0; stable_errs = 0; busy_errs = 0; post_errs = 0;
    rd_since = 0; prev_stall = 0; prev_valid = 0; pl = 0; pd = '0; pr = '0; pc = '0;
    win_ready = 1'b0;
    img_size  = 6'(n);
    start     = 1'b1;
    cyc       = 0;
    step();
    start = 1'b0;
    while (cyc < 20000) begin
      start = (cyc == dup_at);
      if (start) img_size = 6'd5;
      if (done === 1'b1) begin
        done_cyc = cyc;
        if (busy !== 1'b0 || win_valid !== 1'b0 || rd_en !== 1'b0) post_errs++;
        break;
      end
      if (busy !== (n >= K)) busy_errs++;
      if (rd_en === 1'b1) begin
        reads++;
        rd_since++;
        if (win_valid === 1'b1) present_reads++;
      end
      if (prev_stall && (win_valid !== 1'b1 || win_data !== pd || win_row !== pr ||
                         win_col !== pc || win_last !== pl)) stable_errs++;
      if (win_valid === 1'b1 && !prev_valid) begin
        valid_cyc.push_back(cyc);
        bursts.push_back(rd_since);
      end
      win_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (win_valid === 1'b1 && win_ready) begin
        got_data.push_back(win_data);
        got_row.push_back(int'(win_row));
        got_col.push_back(int'(win_col));
        got_last.push_back(int'(win_last === 1'b1));
        hs_cyc.push_back(cyc);
        rd_since = 0;
      end
      prev_stall = (win_valid === 1'b1) && !win_ready;
      pd = win_data; pr = win_row; pc = win_col; pl = (win_last === 1'b1);
      prev_valid = (win_valid === 1'b1);
      step();
    end
    start = 1'b0;
    win_ready = 1'b0;
    if (done_cyc < 0) begin
      tests++;
      fails++;
      $display("FAIL run_timeout: n=%0d, done not seen by cycle %0d", n, cyc);
    end
  endtask

  // Compare the recorded run with windows and timing derived from the image rules.
  task automatic check_run(input string tag, input int n, input int exp_win, input int exp_done);
    int side, nw, m, r, c, derr, rcerr, lerr, terr, berr, expv, exp_reads;
    logic [WW-1:0] ev;
    side = (n >= K) ? n - K + 1 : 0;
    nw = side * side;
    derr = 0; rcerr = 0; lerr = 0; terr = 0; berr = 0;
    check({tag, "_windows"}, got_data.size(), exp_win);
    m = nw;
    if (got_data.size() < m) m = got_data.size();
    if (valid_cyc.size() < m) m = valid_cyc.size();
    if (bursts.size() < m) m = bursts.size();
    for (int i = 0; i < m; i++) begin
      r = i / side;
      c = i % side;
      ev = '0;
      for (int a = 0; a < K; a++)
        for (int b = 0; b < K; b++)
          ev[(a*K+b)*DW +: DW] = mem[(r+a)*n + c + b];
      if (got_data[i] !== ev) derr++;
      if (got_row[i] != r || got_col[i] != c) rcerr++;
      if (got_last[i] != int'(i == nw - 1)) lerr++;
      expv = (i == 0) ? KK + 2 : hs_cyc[i-1] + ((c == 0) ? KK + 2 : K + 2);
      if (valid_cyc[i] != expv) terr++;
      if (bursts[i] != ((c == 0) ? KK : K)) berr++;
    end
    exp_reads = (side == 0) ? 0 : side * (KK + (side - 1) * K);
    check({tag, "_data_errs"}, derr, 0);
    check({tag, "_rowcol_errs"}, rcerr, 0);
    check({tag, "_last_errs"}, lerr, 0);
    check({tag, "_valid_timing_errs"}, terr, 0);
    check({tag, "_burst_errs"}, berr, 0);
    check({tag, "_reads"}, reads, exp_reads);
    check({tag, "_reads_in_present"}, present_reads, 0);
    check({tag, "_stall_unstable"}, stable_errs, 0);
    check({tag, "_busy_errs"}, busy_errs, 0);
    check({tag, "_after_done_errs"}, post_errs, 0);
    if (nw == 0) check({tag, "_done_cycle"}, done_cyc, 1);
    else if (hs_cyc.size() >= nw) check({tag, "_done_cycle"}, done_cyc, hs_cyc[nw-1] + 1);
    if (exp_done >= 0) check({tag, "_done_abs"}, done_cyc, exp_done);
  endtask

  initial begin
    logic [WW-1:0] w;
    logic [WW-1:0] q1 [$];
    int hs, mism;

    vecs[0] = '{5,  1'b0, 1'b0, 1,   28};
    vecs[1] = '{7,  1'b0, 1'b0, 9,   124};
    vecs[2] = '{4,  1'b0, 1'b0, 0,   1};
    vecs[3] = '{6,  1'b1, 1'b1, 4,   -1};
    vecs[4] = '{1,  1'b0, 1'b1, 0,   1};
    vecs[5] = '{32, 1'b0, 1'b1, 784, 6049};
    vecs[6] = '{8,  1'b1, 1'b1, 16,  -1};
    vecs[7] = '{6,  1'b0, 1'b1, 4,   69};

    rst = 1'b1; start = 1'b0; win_ready = 1'b0; img_size = '0;
    fill_mem(1'b0);
    step(); step(); step();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_rd_en", rd_en, 0);
    check("rst_rd_addr", rd_addr, 0);
    check("rst_win_valid", win_valid, 0);
    check("rst_win_last", win_last, 0);
    check("rst_win_row", win_row, 0);
    check("rst_win_col", win_col, 0);
    check("rst_win_data_nonzero", win_data != '0, 0);
    rst = 1'b0;
    step();

    for (int v = 0; v < 8; v++) begin
      fill_mem(vecs[v].rnd_mem);
      run_image(vecs[v].n, vecs[v].rnd_ready, -1);
      check_run($sformatf("vec%0d_n%0d", v, vecs[v].n), vecs[v].n, vecs[v].exp_win, vecs[v].exp_done);
      step();
    end

    // Sliding window contents at (1,2) for N=7 with word = address.
    fill_mem(1'b0);
    run_image(7, 1'b0, -1);
    check_run("slide7", 7, 9, 124);
    if (got_data.size() > 5) begin
      w = got_data[5];
      check("slide7_w12_row", got_row[5], 1);
      check("slide7_w12_col", got_col[5], 2);
      check("slide7_w12_e00", w[15:0], 9);
      check("slide7_w12_e44", w[24*DW +: DW], 41);
    end else begin
      check("slide7_w12_present", got_data.size(), 9);
    end
    step();

    // Backpressured run must yield the same window sequence as a free-running one.
    fill_mem(1'b1);
    run_image(6, 1'b1, -1);
    check_run("bp6", 6, 4, -1);
    q1 = got_data;
    step();
    run_image(6, 1'b0, -1);
    check_run("free6", 6, 4, 69);
    mism = 0;
    if (q1.size() != got_data.size()) mism = 1000;
    else for (int i = 0; i < q1.size(); i++) if (q1[i] !== got_data[i]) mism++;
    check("bp_vs_free_mismatch", mism, 0);
    step();

    // Reset during the SHIFT that builds the third window.
    fill_mem(1'b0);
    img_size = 6'd7; win_ready = 1'b1; start = 1'b1; cyc = 0;
    step();
    start = 1'b0;
    hs = 0;
    while (hs < 2 && cyc < 500) begin
      if (win_valid === 1'b1) hs++;
      step();
    end
    check("rmr_handshakes", hs, 2);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    win_ready = 1'b0;
    check("rmr_busy", busy, 0);
    check("rmr_done", done, 0);
    check("rmr_rd_en", rd_en, 0);
    check("rmr_rd_addr", rd_addr, 0);
    check("rmr_win_valid", win_valid, 0);
    check("rmr_win_last", win_last, 0);
    check("rmr_win_row", win_row, 0);
    check("rmr_win_col", win_col, 0);
    check("rmr_win_data_nonzero", win_data != '0, 0);
    step();
    run_image(5, 1'b0, -1);
    check_run("rmr_restart5", 5, 1, 28);
    step();

    // A second start during an N=7 run is ignored.
    fill_mem(1'b0);
    run_image(7, 1'b0, 10);
    check_run("dupstart7", 7, 9, 124);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
